// File: rtl/exec_trace_buffer.sv
// Circular execution-trace capture: records {pc, regs} on each retire while armed,
// then dumps the history oldest-first over a valid/ready port once the post-trigger window closes.
module exec_trace_buffer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int NUM_REGS   = 3,
    parameter int DEPTH      = 16,
    parameter int POST_COUNT = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                arm,
    input  logic                                abort,
    input  logic                                trig_mode,
    input  logic [ADDR_W-1:0]                   trig_pc,
    input  logic [ADDR_W-1:0]                   pc,
    input  logic                                pc_valid,
    input  logic [NUM_REGS*DATA_W-1:0]          regs,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [ADDR_W+NUM_REGS*DATA_W-1:0]   rd_data,
    output logic                                rd_last,
    output logic [1:0]                          state,
    output logic                                done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int RD_W  = ADDR_W + NUM_REGS * DATA_W;
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] POST_L  = (PTR_W+1)'(POST_COUNT);
    localparam logic [PTR_W:0] ONE_L   = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t             st, st_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     fill;
    logic [PTR_W:0]     post_cnt;
    logic [PTR_W:0]     rd_cnt;
    logic [PTR_W-1:0]   rd_idx;
    logic [RD_W-1:0]    mem [DEPTH];

    logic trigger, capturing, wr_en, handshake;

    assign trigger   = pc_valid && (!trig_mode || (pc == trig_pc));
    assign capturing = (st == S_ARMED) || (st == S_POST);
    assign wr_en     = capturing && pc_valid && !abort;

    // wr_ptr and fill are frozen during the dump, so the oldest entry is wr_ptr - fill.
    assign rd_idx    = wr_ptr - fill[PTR_W-1:0] + rd_cnt[PTR_W-1:0];
    assign rd_valid  = (st == S_DUMP);
    assign rd_data   = rd_valid ? mem[rd_idx] : '0;
    assign rd_last   = rd_valid && (rd_cnt == fill - ONE_L);
    assign handshake = rd_valid && rd_ready;
    assign done      = handshake && rd_last && !abort;
    assign state     = st;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) st <= S_IDLE;
        else       st <= st_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        st_nxt = st;
        unique case (st)
            S_IDLE:  if (arm) st_nxt = S_ARMED;
            S_ARMED: if (trigger) st_nxt = (POST_L == ONE_L) ? S_DUMP : S_POST;
            S_POST:  if (pc_valid && (post_cnt + ONE_L == POST_L)) st_nxt = S_DUMP;
            S_DUMP:  if (handshake && rd_last) st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
        if (abort) st_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            if (st == S_IDLE && arm && !abort) begin
                wr_ptr   <= '0;
                fill     <= '0;
                post_cnt <= '0;
                rd_cnt   <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != DEPTH_L) fill <= fill + ONE_L;
                if (st == S_ARMED && trigger) post_cnt <= ONE_L;
                else if (st == S_POST)        post_cnt <= post_cnt + ONE_L;
            end
            if (handshake) rd_cnt <= rd_cnt + ONE_L;
        end
    end

    // NOTE: the trace array has no reset; fill bounds what is ever read back, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {pc, regs};
    end

endmodule
